// File: rtl/weather_tree_engine.sv
// weather_tree_engine: programmable decision-tree classifier for the weather predictor.
// A runtime-written node table is walked one node per clock. Each query yields a class
// code, with an error flag for runaway depth or bad child links.
// Optional feature macro: TREE_PATH_EN adds out_path/out_depth (the branch trace).
module weather_tree_engine #(
    parameter int FEAT_W    = 5,
    parameter int N_FEAT    = 4,
    parameter int N_NODES   = 16,
    parameter int CLASS_W   = 3,
    parameter int MAX_DEPTH = 8,
    localparam int NIDX_W   = $clog2(N_NODES),
    localparam int FIDX_W   = $clog2(N_FEAT),
    localparam int DEP_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    input  logic                     cfg_we,
    input  logic [NIDX_W-1:0]        cfg_addr,
    input  logic                     cfg_leaf,
    input  logic [FIDX_W-1:0]        cfg_feat,
    input  logic [FEAT_W-1:0]        cfg_thresh,
    input  logic [NIDX_W-1:0]        cfg_left,
    input  logic [NIDX_W-1:0]        cfg_right,
    input  logic [CLASS_W-1:0]       cfg_class,
    output logic                     cfg_drop
`ifdef TREE_PATH_EN
    ,
    output logic [MAX_DEPTH-1:0]     out_path,
    output logic [DEP_W-1:0]         out_depth
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [NIDX_W:0]  NODES_LIM = N_NODES[NIDX_W:0];
    localparam logic [DEP_W-1:0] DEPTH_LIM = MAX_DEPTH[DEP_W-1:0];

    // Feature select; an index with no matching feature reads as zero.
    function automatic logic [FEAT_W-1:0] pick_feat(
        input logic [N_FEAT*FEAT_W-1:0] vec,
        input logic [FIDX_W-1:0]        sel
    );
        pick_feat = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (sel == FIDX_W'(i)) pick_feat = vec[i*FEAT_W +: FEAT_W];
        end
    endfunction

    logic [1:0]               state_q;
    logic [N_FEAT*FEAT_W-1:0] feat_p0;
    logic [NIDX_W-1:0]        node_q;
    logic [DEP_W-1:0]         depth_q;

    logic                     nd_leaf   [N_NODES];
    logic [FIDX_W-1:0]        nd_feat   [N_NODES];
    logic [FEAT_W-1:0]        nd_thresh [N_NODES];
    logic [NIDX_W-1:0]        nd_left   [N_NODES];
    logic [NIDX_W-1:0]        nd_right  [N_NODES];
    logic [CLASS_W-1:0]       nd_class  [N_NODES];

    logic                     go_left;
    logic [NIDX_W-1:0]        nxt_idx;
    logic                     walk_err;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    // Branch decision and error detection for the node currently being visited.
    always_comb begin
        go_left  = pick_feat(feat_p0, nd_feat[node_q]) <= nd_thresh[node_q];
        nxt_idx  = go_left ? nd_left[node_q] : nd_right[node_q];
        walk_err = (depth_q == DEPTH_LIM) || ({1'b0, nxt_idx} >= NODES_LIM);
    end

    // Node table: written only while idle; reset leaves an all-"unknown" tree.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_NODES; n++) begin
                nd_leaf[n]   <= 1'b1;
                nd_feat[n]   <= '0;
                nd_thresh[n] <= '0;
                nd_left[n]   <= '0;
                nd_right[n]  <= '0;
                nd_class[n]  <= '1;
            end
        end else if (cfg_we && state_q == ST_IDLE) begin
            nd_leaf[cfg_addr]   <= cfg_leaf;
            nd_feat[cfg_addr]   <= cfg_feat;
            nd_thresh[cfg_addr] <= cfg_thresh;
            nd_left[cfg_addr]   <= cfg_left;
            nd_right[cfg_addr]  <= cfg_right;
            nd_class[cfg_addr]  <= cfg_class;
        end
    end

    // Flag configuration writes that arrive while a query is in flight.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) cfg_drop <= 1'b0;
        else     cfg_drop <= cfg_we && (state_q != ST_IDLE);
    end

    // Query FSM: accept -> walk one node per clock -> hold result until taken.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            feat_p0   <= '0;
            node_q    <= '0;
            depth_q   <= '0;
            out_class <= '1;
            out_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_p0 <= in_feat;
                        node_q  <= '0;
                        depth_q <= '0;
                        state_q <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (nd_leaf[node_q]) begin
                        out_class <= nd_class[node_q];
                        out_err   <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (walk_err) begin
                        out_class <= '1;
                        out_err   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        node_q  <= nxt_idx;
                        depth_q <= depth_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TREE_PATH_EN
    // Branch trace: bit k records that step k took the right child.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            out_path <= '0;
        end else if (state_q == ST_IDLE && in_valid) begin
            out_path <= '0;
        end else if (state_q == ST_WALK && !nd_leaf[node_q] && !walk_err && !go_left) begin
            out_path <= out_path | (MAX_DEPTH'(1) << depth_q);
        end
    end

    assign out_depth = depth_q;
`endif

endmodule

// File: tb/tb_weather_tree_engine.sv
// Directed testbench for weather_tree_engine. The DUT is built with N_NODES=12 so that a
// 4-bit child link can point past the end of the table.
// Define TREE_PATH_EN to also check the branch trace outputs.
module tb_weather_tree_engine;

    localparam int FEAT_W = 5, N_FEAT = 4, N_NODES = 12, CLASS_W = 3, MAX_DEPTH = 8;
    localparam int NIDX_W = $clog2(N_NODES), FIDX_W = $clog2(N_FEAT), DEP_W = $clog2(MAX_DEPTH + 1);

    logic                     CLOCK_50 = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [CLASS_W-1:0]       out_class;
    logic                     out_err;
    logic                     cfg_we = 1'b0;
    logic [NIDX_W-1:0]        cfg_addr = '0;
    logic                     cfg_leaf = 1'b0;
    logic [FIDX_W-1:0]        cfg_feat = '0;
    logic [FEAT_W-1:0]        cfg_thresh = '0;
    logic [NIDX_W-1:0]        cfg_left = '0;
    logic [NIDX_W-1:0]        cfg_right = '0;
    logic [CLASS_W-1:0]       cfg_class = '0;
    logic                     cfg_drop;
`ifdef TREE_PATH_EN
    logic [MAX_DEPTH-1:0]     out_path;
    logic [DEP_W-1:0]         out_depth;
`endif

    int total = 0;
    int bad   = 0;
    int lat;

    weather_tree_engine #(
        .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .N_NODES(N_NODES),
        .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_leaf(cfg_leaf),
        .cfg_feat(cfg_feat), .cfg_thresh(cfg_thresh),
        .cfg_left(cfg_left), .cfg_right(cfg_right),
        .cfg_class(cfg_class), .cfg_drop(cfg_drop)
`ifdef TREE_PATH_EN
        ,
        .out_path(out_path), .out_depth(out_depth)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cfg_write(input int addr, input bit leaf, input int f, input int th,
                             input int l, input int r, input int cls);
        cfg_we     = 1'b1;
        cfg_addr   = NIDX_W'(addr);
        cfg_leaf   = leaf;
        cfg_feat   = FIDX_W'(f);
        cfg_thresh = FEAT_W'(th);
        cfg_left   = NIDX_W'(l);
        cfg_right  = NIDX_W'(r);
        cfg_class  = CLASS_W'(cls);
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic [N_FEAT*FEAT_W-1:0] pack(input int f0, input int f1, input int f2, input int f3);
        return {FEAT_W'(f3), FEAT_W'(f2), FEAT_W'(f1), FEAT_W'(f0)};
    endfunction

    // Present a query, accept it, and wait (bounded) for the result; lat = cycles after accept cycle.
    task automatic query(input int f0, input int f1, input int f2, input int f3);
        in_feat  = pack(f0, f1, f2, f3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_feat  = pack(31, 31, 31, 31);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic program_tree();
        cfg_write(0, 0, 0, 17, 1, 2, 0);
        cfg_write(1, 0, 2, 1, 5, 3, 0);
        cfg_write(2, 0, 0, 26, 4, 5, 0);
        cfg_write(3, 0, 1, 1, 6, 7, 0);
        cfg_write(4, 0, 2, 1, 5, 7, 0);
        cfg_write(5, 1, 0, 0, 0, 0, 3'b000);
        cfg_write(6, 1, 0, 0, 0, 0, 3'b110);
        cfg_write(7, 1, 0, 0, 0, 0, 3'b001);
    endtask

    initial begin
        // Power-on reset
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 3'b111);
        chk("rst_cfg_drop", cfg_drop, 0);
        rst = 1'b0;
        tick(); tick();

        // Reset pulse mid-idle
        rst = 1'b1;
        #3;
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();

        // Unprogrammed tree answers unknown after 2 cycles
        query(10, 0, 2, 4);
        chk("unprog_lat", lat, 2);
        chk("unprog_class", out_class, 3'b111);
        chk("unprog_err", out_err, 0);
        take();
        chk("unprog_taken", out_valid, 0);

        program_tree();

        // Weather queries
        query(10, 0, 2, 4);
        chk("snow_lat", lat, 5);
        chk("snow_class", out_class, 3'b110);
        chk("snow_err", out_err, 0);
`ifdef TREE_PATH_EN
        chk("snow_depth", out_depth, 3);
        chk("snow_path", out_path, 8'b0000_0010);
`endif
        take();
        query(20, 5, 3, 1);
        chk("rain_lat", lat, 5);
        chk("rain_class", out_class, 3'b001);
        take();
        query(30, 10, 0, 0);
        chk("sun_lat", lat, 4);
        chk("sun_class", out_class, 3'b000);
        take();
        // Feature equal to threshold goes left at every step: n0 -> n1 -> n5
        query(17, 0, 1, 0);
        chk("eq_lat", lat, 4);
        chk("eq_class", out_class, 3'b000);
        take();

        // Backpressure: result held, new query ignored
        query(20, 5, 3, 1);
        in_feat  = pack(10, 0, 2, 4);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_class", out_class, 3'b001);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        take();
        chk("bp_taken_valid", out_valid, 0);
        chk("bp_taken_ready", in_ready, 1);

        // Config write during WALK is dropped
        in_feat  = pack(10, 0, 2, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_write(6, 1, 0, 0, 0, 0, 3'b000);
        chk("drop_pulse", cfg_drop, 1);
        tick();
        chk("drop_clear", cfg_drop, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("drop_class", out_class, 3'b110);
        take();
        query(10, 0, 2, 4);
        chk("drop_table_kept", out_class, 3'b110);
        take();

        // Same-cycle write and accept: query sees the new leaf class
        in_feat  = pack(10, 0, 2, 4);
        in_valid = 1'b1;
        cfg_write(6, 1, 0, 0, 0, 0, 3'b010);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("same_cyc_lat", lat, 5);
        chk("same_cyc_class", out_class, 3'b010);
        take();

        // Reset mid-WALK clears the table
        in_feat  = pack(10, 0, 2, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstwalk_valid", out_valid, 0);
        chk("rstwalk_ready", in_ready, 1);
        rst = 1'b0;
        tick();
        query(10, 0, 2, 4);
        chk("rstwalk_class", out_class, 3'b111);
        chk("rstwalk_lat", lat, 2);
        take();

        // Self-loop trips the depth limit
        cfg_write(0, 0, 0, 17, 0, 0, 0);
        query(5, 5, 5, 5);
        chk("loop_lat", lat, MAX_DEPTH + 2);
        chk("loop_err", out_err, 1);
        chk("loop_class", out_class, 3'b111);
        take();

        // Child index beyond the table
        cfg_write(0, 0, 0, 31, 13, 13, 0);
        query(5, 5, 5, 5);
        chk("badchild_lat", lat, 2);
        chk("badchild_err", out_err, 1);
        chk("badchild_class", out_class, 3'b111);
        take();

        // A good result clears the error flag
        cfg_write(0, 1, 0, 0, 0, 0, 3'b001);
        query(5, 5, 5, 5);
        chk("recover_err", out_err, 0);
        chk("recover_class", out_class, 3'b001);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
